// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional fault checking is enabled with `define DMEM_ERRCHK_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Access width in bytes for a funct3[1:0] size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage and the responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane store merge and load extraction/extension for one 64-bit word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [63:0] wdata,
  output logic [63:0] merged,
  output logic [63:0] load_val
);

  logic [5:0]  sh;
  logic [63:0] byte_mask;
  logic [63:0] shifted;

  assign sh = {lane, 3'b000};

  // Build the lane mask, merge store bytes and extend the loaded field.
  always_comb begin
    byte_mask = '1;
    load_val  = '0;
    case (size)
      SZ_B:    byte_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    byte_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    byte_mask = 64'h0000_0000_FFFF_FFFF;
      default: byte_mask = '1;
    endcase
    merged  = (word & ~(byte_mask << sh)) | ((wdata << sh) & (byte_mask << sh));
    shifted = word >> sh;
    case (size)
      SZ_B:    load_val = zext ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    load_val = zext ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    load_val = zext ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one request at a time, sized
// little-endian access to a DEPTH x 64-bit array.
// `define DMEM_ERRCHK_EN to fault misaligned/out-of-range accesses;
// otherwise addresses are aligned down and the index wraps.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic             Clk,
  input logic             Rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, access;

  logic        wr_q, uns_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q, wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic [2:0]       size_mask;
  logic             fault;
  logic [63:0]      word, merged, load_val;

  assign size_mask = 3'(size_bytes(size_q) - 4'd1);
  assign idx       = addr_q[3 +: IDX_W];
  assign word      = mem[idx];

`ifdef DMEM_ERRCHK_EN
  assign lane  = addr_q[2:0];
  assign fault = ((addr_q[2:0] & size_mask) != '0) || (addr_q[63:3] >= 61'(DEPTH));
`else
  assign lane  = addr_q[2:0] & ~size_mask;
  assign fault = 1'b0;
`endif

  dmem_lane_align u_align (
    .word     (word),
    .lane     (lane),
    .size     (size_q),
    .zext     (uns_q),
    .wdata    (wdata_q),
    .merged   (merged),
    .load_val (load_val)
  );

  // Next-state, wait counter and handshake outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    access        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = WS;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, latched request and registered response.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (access) begin
        rdata_q <= (wr_q || fault) ? '0 : load_val;
        err_q   <= fault;
      end
    end
  end

  // Array write at the edge leaving WAIT; contents are not reset.
  always_ff @(posedge Clk) begin
    if (access && wr_q && !fault) mem[idx] <= merged;
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;
  localparam int          LAT   = WS + 1;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] bmem [DEPTH*8];

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference: byte-addressed memory with the access rules applied arithmetically.
  function automatic void model_access(input bit wr, input logic [1:0] sz, input bit uns,
                                       input logic [63:0] addr, input logic [63:0] wd,
                                       output logic [63:0] rd, output logic er);
    longint unsigned n = 64'd1 << sz;
    longint unsigned a = addr;
    logic [63:0] v, tmp, ones;
    rd = '0;
    er = 1'b0;
`ifdef DMEM_ERRCHK_EN
    if ((a % n) != 0 || (a / 8) >= DEPTH) begin
      er = 1'b1;
      return;
    end
`else
    a = (a / n) * n;
    a = a % (DEPTH * 8);
`endif
    if (wr) begin
      for (int i = 0; i < int'(n); i++) begin
        tmp = wd >> (8 * i);
        bmem[a + i] = tmp[7:0];
      end
    end else begin
      v = '0;
      for (int i = 0; i < int'(n); i++) v = v | (64'(bmem[a + i]) << (8 * i));
      if (!uns && n < 8 && v[8*n-1]) begin
        ones = '1;
        v = v | (ones << (8 * n));
      end
      rd = v;
    end
  endfunction

  // One full transaction from IDLE; lat = edges from accept to rsp_valid, -1 on timeout.
  task automatic do_txn(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat > 0) begin
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(posedge Clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_fill;
    logic [63:0] rd, erd, wd; logic er, eer; int lat;
    for (int w = 0; w < int'(DEPTH); w++) begin
      wd = {$urandom, $urandom};
      model_access(1'b1, 2'b11, 1'b0, 64'(w * 8), wd, erd, eer);
      do_txn(1'b1, 2'b11, 1'b0, 64'(w * 8), wd, rd, er, lat);
      checks++; if (lat !== LAT || er !== 1'b0 || rd !== 64'd0) begin
        errors++; $display("FAIL fill_store w=%0d lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=0", w, lat, er, rd, LAT);
      end
    end
  endtask

  task automatic test_dword;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model_access(1'b1, 2'b11, 1'b0, 64'h40, 64'h1122334455667788, erd, eer);
    do_txn(1'b1, 2'b11, 1'b0, 64'h40, 64'h1122334455667788, rd, er, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL sd_latency got %0d want %0d", lat, LAT); end
    do_txn(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rd, er, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ld_latency got %0d want %0d", lat, LAT); end
    checks++; if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++; $display("FAIL ld_dword got %h err=%b want 1122334455667788 err=0", rd, er);
    end
  endtask

  task automatic test_extension;
    logic [63:0] rd; logic er; int lat;
    do_txn(1'b0, 2'b00, 1'b0, 64'h40, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'hFFFFFFFFFFFFFF88) begin errors++; $display("FAIL lb got %h want ffffffffffffff88", rd); end
    do_txn(1'b0, 2'b00, 1'b1, 64'h40, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h88) begin errors++; $display("FAIL lbu got %h want 88", rd); end
    do_txn(1'b0, 2'b01, 1'b0, 64'h46, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h1122) begin errors++; $display("FAIL lh got %h want 1122", rd); end
  endtask

  task automatic test_merge;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model_access(1'b1, 2'b00, 1'b0, 64'h41, 64'hAB, erd, eer);
    do_txn(1'b1, 2'b00, 1'b0, 64'h41, 64'hAB, rd, er, lat);
    do_txn(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h112233445566AB88) begin errors++; $display("FAIL sb_merge got %h want 112233445566ab88", rd); end
  endtask

  task automatic test_backpressure;
    logic [63:0] held, rd, erd; logic er, eer; int lat;
    bit seen;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b11;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'h40; bus.req_wdata = '0;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_response_timeout got none want rsp_valid"); end
    held = bus.rsp_rdata;
    // Offer a second request while the response is stalled.
    bus.req_valid = 1'b1; bus.req_addr = 64'h48;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall cyc=%0d valid=%b rdata=%h req_ready=%b want 1 %h 0", k, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held);
      end
    end
    checks++; if (held !== 64'h112233445566AB88) begin errors++; $display("FAIL bp_data got %h want 112233445566ab88", held); end
    bus.rsp_ready = 1'b1;
    @(posedge Clk); #1;
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_back_idle valid=%b req_ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept req_ready=%b want 0", bus.req_ready); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (bus.rsp_valid === 1'b1) begin lat = k; break; end
    end
    rd = bus.rsp_rdata;
    model_access(1'b0, 2'b11, 1'b0, 64'h48, 64'd0, erd, eer);
    checks++; if (lat !== LAT || rd !== erd) begin
      errors++; $display("FAIL bp_second_rsp lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rd, LAT, erd);
    end
    bus.rsp_ready = 1'b1;
    @(posedge Clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_faults;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model_access(1'b1, 2'b10, 1'b0, 64'h42, 64'hCAFEBABE, erd, eer);
    do_txn(1'b1, 2'b10, 1'b0, 64'h42, 64'hCAFEBABE, rd, er, lat);
`ifdef DMEM_ERRCHK_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_misaligned_err got %b want 1", er); end
    do_txn(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h112233445566AB88) begin errors++; $display("FAIL sw_fault_nowrite got %h want 112233445566ab88", rd); end
    do_txn(1'b0, 2'b11, 1'b0, 64'(DEPTH * 8), 64'd0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL ld_oob got err=%b rdata=%h want 1 0", er, rd); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_misaligned_err got %b want 0", er); end
    do_txn(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h11223344CAFEBABE) begin errors++; $display("FAIL sw_aligned_down got %h want 11223344cafebabe", rd); end
    model_access(1'b0, 2'b11, 1'b0, 64'(DEPTH * 8), 64'd0, erd, eer);
    do_txn(1'b0, 2'b11, 1'b0, 64'(DEPTH * 8), 64'd0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== erd) begin errors++; $display("FAIL ld_wrap got err=%b rdata=%h want 0 %h", er, rd, erd); end
`endif
  endtask

  task automatic test_reset_midflight;
    logic [63:0] rd, erd; logic er, eer; int lat;
    // Reset in WAIT: store is dropped, model untouched.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b11;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'h80; bus.req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    #2 Rst_n = 1'b0;
    #2;
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_outputs req_ready=%b rsp_valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    model_access(1'b0, 2'b11, 1'b0, 64'h80, 64'd0, erd, eer);
    do_txn(1'b0, 2'b11, 1'b0, 64'h80, 64'd0, rd, er, lat);
    checks++; if (rd !== erd) begin errors++; $display("FAIL rst_wait_nocommit got %h want %h", rd, erd); end
    // Reset in RESP: store already committed.
    bus.req_valid = 1'b1; bus.req_addr = 64'h88; bus.req_write = 1'b1; bus.req_wdata = 64'h0123_4567_89AB_CDEF;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    repeat (LAT) @(posedge Clk);
    #1 Rst_n = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    model_access(1'b1, 2'b11, 1'b0, 64'h88, 64'h0123_4567_89AB_CDEF, erd, eer);
    do_txn(1'b0, 2'b11, 1'b0, 64'h88, 64'd0, rd, er, lat);
    checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rst_resp_committed got %h want 0123456789abcdef", rd); end
  endtask

  task automatic test_random;
    logic [63:0] rd, erd, addr, wd; logic er, eer; int lat;
    logic [1:0] sz; bit wr, uns; int unsigned r;
    for (int t = 0; t < 300; t++) begin
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      wd  = {$urandom, $urandom};
      r   = $urandom_range(0, 9);
      if (r < 8)       addr = 64'($urandom_range(0, DEPTH * 8 - 1));
      else if (r == 8) addr = 64'(DEPTH * 8 + $urandom_range(0, DEPTH * 8 - 1));
      else             addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = (addr >> sz) << sz;
      model_access(wr, sz, uns, addr, wd, erd, eer);
      do_txn(wr, sz, uns, addr, wd, rd, er, lat);
      checks++; if (lat !== LAT || rd !== erd || er !== eer) begin
        errors++; $display("FAIL random t=%0d wr=%0d sz=%0d uns=%0d addr=%h lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                           t, wr, sz, uns, addr, lat, rd, er, LAT, erd, eer);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    test_reset;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    test_reset;
    test_fill;
    test_dword;
    test_extension;
    test_merge;
    test_backpressure;
    test_faults;
    test_reset_midflight;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
